// File: rtl/andrewm_uart_pkg.sv
// rtl/andrewm_uart_pkg.sv - shared UART types and constants for the rx and tx blocks
package andrewm_uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

// File: rtl/andrewm_uart_to_parallel_if.sv
// rtl/andrewm_uart_to_parallel_if.sv - serial line in, received byte and status out
interface andrewm_uart_to_parallel_if;
  import andrewm_uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx,
    output data, data_valid, frame_err, parity_err, busy
  );

  modport slave (
    output rx,
    input  data, data_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/andrewm_uart_rx_sync.sv
// rtl/andrewm_uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx line, resets to idle-high
module andrewm_uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/andrewm_uart_to_parallel_core.sv
// rtl/andrewm_uart_to_parallel_core.sv - UART receive FSM; UART_RX_PARITY_EN selects 8E1 instead of 8N1
module andrewm_uart_to_parallel_core
  import andrewm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  andrewm_uart_to_parallel_if.master bus
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 rx_s;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  andrewm_uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.rx),
    .q_o    (rx_s)
  );

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    if (!tick) cnt_d = cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
            cnt_d   = CNT_FULL;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_s;
          cnt_d   = CNT_FULL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Parity is only judged once the stop bit is good; a bad stop wins.
        if (tick) begin
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_q != ^shift_q) begin
              pe_d = 1'b1;
            end else begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end
`else
            data_d = shift_q;
            dv_d   = 1'b1;
`endif
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: rtl/andrewm_uart_to_parallel.sv
// rtl/andrewm_uart_to_parallel.sv - UART receiver top; define UART_RX_PARITY_EN for 8E1 frames
module andrewm_uart_to_parallel
  import andrewm_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  andrewm_uart_to_parallel_if u_bus ();

  assign u_bus.rx = rx;

  andrewm_uart_to_parallel_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_bus.master)
  );

  assign data       = u_bus.data;
  assign data_valid = u_bus.data_valid;
  assign frame_err  = u_bus.frame_err;
  assign parity_err = u_bus.parity_err;
  assign busy       = u_bus.busy;

endmodule

// File: tb/tb_andrewm_uart_to_parallel.sv
// tb/tb_andrewm_uart_to_parallel.sv - scoreboard bench for the UART receiver (honours UART_RX_PARITY_EN)
module tb_andrewm_uart_to_parallel;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 79 + CPB;
  localparam bit PAR = 1'b1;
`else
  localparam int LAT = 79;
  localparam bit PAR = 1'b0;
`endif
  localparam int K_VALID = 0;
  localparam int K_FRAME = 1;
  localparam int K_PARITY = 2;

  typedef struct {
    int       kind;
    logic [7:0] data;
    int       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [7:0] last_good = 8'h00;

  andrewm_uart_to_parallel_if u_if ();

  andrewm_uart_to_parallel #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (u_if.rx),
    .data       (u_if.data),
    .data_valid (u_if.data_valid),
    .frame_err  (u_if.frame_err),
    .parity_err (u_if.parity_err),
    .busy       (u_if.busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cyc %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (u_if.data_valid || u_if.frame_err || u_if.parity_err)) begin
      chk("one_pulse", int'(u_if.data_valid) + int'(u_if.frame_err) + int'(u_if.parity_err), 1);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=pulse required=none at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind", u_if.data_valid ? K_VALID : (u_if.frame_err ? K_FRAME : K_PARITY), e.kind);
        chk("data", int'(u_if.data), int'(e.data));
        chk("latency", cyc, e.cyc);
        if (u_if.data_valid) chk("busy_on_valid", int'(u_if.busy), 0);
      end
    end
  end

  task automatic drive(input logic v, input int n);
    u_if.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome comes from frame content alone: bad stop beats bad parity beats good byte.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles,
                            input logic par_flip);
    exp_t e;
    e.cyc = cyc + LAT;
    if (!stop_v) begin
      e.kind = K_FRAME;
      e.data = last_good;
    end else if (PAR && par_flip) begin
      e.kind = K_PARITY;
      e.data = last_good;
    end else begin
      e.kind = K_VALID;
      e.data = b;
      last_good = b;
    end
    sb.push_back(e);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (PAR) drive((^b) ^ par_flip, CPB);
    drive(stop_v, stop_cycles);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  initial begin
    int   seen_idle;
    logic [7:0] b;
    rst_n = 1'b0;
    u_if.rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", int'(u_if.data), 0);
    chk("rst_valid", int'(u_if.data_valid), 0);
    chk("rst_frame_err", int'(u_if.frame_err), 0);
    chk("rst_parity_err", int'(u_if.parity_err), 0);
    chk("rst_busy", int'(u_if.busy), 1);
    rst_n = 1'b1;
    drive(1'b1, 6);
    chk("idle_busy", int'(u_if.busy), 0);

    send_frame(8'hA5, 1'b1, CPB, 1'b0);
    drive(1'b1, 12);
    drain("drain_a5");
    chk("a5_data_hold", int'(u_if.data), 8'hA5);
    chk("a5_busy_after", int'(u_if.busy), 0);

    send_frame(8'h00, 1'b1, CPB / 2 + 1, 1'b0);
    send_frame(8'hFF, 1'b1, CPB, 1'b0);
    drive(1'b1, 12);
    drain("drain_b2b");

    drive(1'b0, 3);
    u_if.rx = 1'b1;
    seen_idle = 0;
    for (int i = 0; i < 8 && seen_idle == 0; i++) begin
      @(negedge clk);
      if (!u_if.busy) seen_idle = 1;
    end
    chk("false_start_idle", seen_idle, 1);
    drive(1'b1, 10);
    chk("false_start_data", int'(u_if.data), 8'hFF);

    send_frame(8'h3C, 1'b0, CPB, 1'b0);
    drive(1'b0, 40);
    drive(1'b1, 4);
    send_frame(8'h42, 1'b1, CPB, 1'b0);
    drive(1'b1, 12);
    drain("drain_frame_err");
    chk("after_ferr_data", int'(u_if.data), 8'h42);

    b = 8'h55;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(b[i], CPB);
    drive(b[4], CPB / 2);
    rst_n = 1'b0;
    last_good = 8'h00;
    for (int i = 0; i < 10; i++) drive(~u_if.rx, 1);
    chk("midrst_data", int'(u_if.data), 0);
    chk("midrst_valid", int'(u_if.data_valid), 0);
    chk("midrst_frame_err", int'(u_if.frame_err), 0);
    drive(1'b1, 3);
    rst_n = 1'b1;
    drive(1'b1, 4);
    send_frame(8'h96, 1'b1, CPB, 1'b0);
    drive(1'b1, 12);
    drain("drain_96");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, CPB, 1'b0);
    send_frame(8'h07 ^ 8'h00, 1'b1, CPB, 1'b1);
    drive(1'b1, 12);
    drain("drain_parity");
    chk("parity_data_hold", int'(u_if.data), 8'h07);
`endif

    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1'b0, CPB, 1'b0);
        drive(1'b0, $urandom_range(5, 30));
        drive(1'b1, $urandom_range(1, 6));
      end else begin
        send_frame(b, 1'b1, $urandom_range(CPB / 2 + 1, 2 * CPB), 1'($urandom_range(0, 3) == 0));
      end
    end
    drive(1'b1, 12);
    drain("drain_random");
    chk("final_data", int'(u_if.data), int'(last_good));
    chk("final_busy", int'(u_if.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/andrewm_uart_to_parallel.md
ANDREWM_UART_TO_PARALLEL -- requirements
Module: andrewm_uart_to_parallel

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per UART bit; legal: even values >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous UART serial line, idle high.
REQ-005 SHALL have port data  output  8  last correctly received byte.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when data updates.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch (see Configuration).
REQ-009 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-012 IDLE: rx_s==0 SHALL go to START and load bit counter with CLKS_PER_BIT/2-1.
REQ-013 START: at counter zero, rx_s==1 (false start) SHALL return to IDLE with no output pulse; rx_s==0 SHALL go to DATA, bit index 0, counter CLKS_PER_BIT-1.
REQ-014 DATA: each counter expiry SHALL sample rx_s into shift register LSB-first; after bit 7 SHALL go to PARITY (macro defined) or STOP.
REQ-015 STOP: at counter expiry, rx_s==1 SHALL load data from shift register and pulse data_valid the following cycle, then IDLE.
REQ-016 STOP: rx_s==0 SHALL pulse frame_err, leave data unchanged, go to WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL remain until rx_s==1 for one cycle, then IDLE (break/stuck-low never re-triggers a frame).
REQ-018 data SHALL hold its value until the next good frame; no consumer handshake, no overrun flag.
REQ-019 Latency: data_valid SHALL assert exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after first low rx cycle (8N1).
REQ-020 Back-to-back frames (start bit immediately after stop midpoint) SHALL be received without loss.
REQ-021 data_valid, frame_err, parity_err SHALL never assert in the same cycle as one another.

Reset
REQ-022 While rst_n==0: data=0, data_valid=0, frame_err=0, parity_err=0, synchronizer flops=1, counters=0, FSM=WAIT_IDLE.
REQ-023 Reset mid-frame SHALL discard the partial byte; after release the FSM SHALL wait for rx_s==1 before accepting a start bit.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit; mismatch with even parity of the 8 data bits SHALL pulse parity_err at stop-bit time instead of data_valid, data unchanged; latency grows by CLKS_PER_BIT.
REQ-025 Macro undefined: frame is 8N1, PARITY state unreachable, parity_err tied 0.

Structure
REQ-026 Package andrewm_uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and default CLKS_PER_BIT, shared with andrewm_parallel_to_uart.
REQ-027 Sub-module andrewm_uart_rx_sync SHALL implement the 2-flop synchronizer (reset value 1).

Verification (CLKS_PER_BIT=8, macro undefined unless stated)
REQ-028 Send 0xA5 8N1 -> data=0xA5, data_valid single pulse at cycle 79 after first rx-low cycle, busy low after.
REQ-029 Send 0x00 then 0xFF back-to-back -> two data_valid pulses, data 0x00 then 0xFF, no errors.
REQ-030 rx low for 3 cycles then high -> no pulse, FSM back in IDLE, busy low within 8 cycles.
REQ-031 Send 0x3C with stop bit 0, hold rx low 40 cycles, then send 0x42 -> frame_err one pulse, data stays prior value, then data=0x42.
REQ-032 Assert rst_n low at DATA bit 4 of 0x55 while rx keeps toggling -> outputs 0, no data_valid; next clean 0x96 received correctly.
REQ-033 UART_RX_PARITY_EN: 0x07 with parity 1 -> data=0x07 valid; same byte with parity 0 -> parity_err pulse, data unchanged.
